// File: rtl/dprf_arb.sv
// Port-2 arbiter/sequencer for the dual-port frame RAM: CPU (requester 0, priority)
// and loader/DMA (requester 1) share one read/write port through a 3-cycle access FSM.
module dprf_arb #(
    parameter int KB     = 16,
    parameter int MAXRUN = 4,
    localparam int AW    = $clog2(KB * 1024)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          rq0,
    input  logic          wr0,
    input  logic [AW-1:0] a0,
    input  logic [7:0]    d0,
    output logic [7:0]    q0,
    output logic          ack0,
    input  logic          rq1,
    input  logic          wr1,
    input  logic [AW-1:0] a1,
    input  logic [7:0]    d1,
    output logic [7:0]    q1,
    output logic          ack1,
    output logic          ce2,
    output logic          we2,
    output logic [AW-1:0] a2,
    output logic [7:0]    d2,
    input  logic [7:0]    q2
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    localparam logic [3:0] RUN_MAX = 4'(MAXRUN);

    logic [1:0] r_state;
    logic [3:0] r_run;
    logic       r_grant;
    logic       r_wr;
    logic       w_grant;

    // Requester 1 wins when it is alone or when requester 0 has used up its run
    assign w_grant = rq1 && (!rq0 || (r_run == RUN_MAX));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_run   <= 4'd0;
            r_grant <= 1'b0;
            r_wr    <= 1'b0;
            ce2     <= 1'b0;
            we2     <= 1'b1;
            a2      <= '0;
            d2      <= 8'h00;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            q0      <= 8'h00;
            q1      <= 8'h00;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    ce2 <= 1'b0;
                    we2 <= 1'b1;
                    if (!rq1) begin
                        r_run <= 4'd0;
                    end
                    if (rq0 || rq1) begin
                        r_grant <= w_grant;
                        r_wr    <= w_grant ? wr1 : wr0;
                        we2     <= w_grant ? ~wr1 : ~wr0;
                        a2      <= w_grant ? a1 : a0;
                        d2      <= w_grant ? d1 : d0;
                        ce2     <= 1'b1;
                        r_state <= S_ISSUE;
                        if (w_grant) begin
                            r_run <= 4'd0;
                        end else if (rq1 && (r_run != RUN_MAX)) begin
                            r_run <= r_run + 4'd1;
                        end
                    end
                end
                S_ISSUE: begin
                    ce2     <= 1'b0;
                    we2     <= 1'b1;
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    // q2 now holds the word the RAM sampled on the ISSUE edge
                    if (r_grant) begin
                        ack1 <= 1'b1;
                        if (!r_wr) begin
                            q1 <= q2;
                        end
                    end else begin
                        ack0 <= 1'b1;
                        if (!r_wr) begin
                            q0 <= q2;
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dprf_arb.sv
// Self-checking bench for dprf_arb: behavioural frame RAM, table-driven single accesses,
// scoreboard of expected acks, and hand sequences for fairness, collisions and reset.
module tb_dprf_arb;

    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          rq0 = 1'b0, wr0 = 1'b0, rq1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] a0 = '0, a1 = '0;
    logic [7:0]    d0 = 8'h00, d1 = 8'h00;
    logic [7:0]    q0, q1, d2, q2;
    logic          ack0, ack1, ce2, we2;
    logic [AW-1:0] a2;

    logic [7:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        int       who;
        bit       isRead;
        bit [7:0] q;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int       who;
        bit       wr;
        bit [13:0] addr;
        bit [7:0] data;
        bit [7:0] expQ;
    } vec_t;
    vec_t vecs [7];

    dprf_arb #(.KB(16), .MAXRUN(4)) dut (
        .clock(clock), .reset(reset),
        .rq0(rq0), .wr0(wr0), .a0(a0), .d0(d0), .q0(q0), .ack0(ack0),
        .rq1(rq1), .wr1(wr1), .a1(a1), .d1(d1), .q1(q1), .ack1(ack1),
        .ce2(ce2), .we2(we2), .a2(a2), .d2(d2), .q2(q2)
    );

    always #5 clock = ~clock;

    // Frame RAM port 2: registered read, read-before-write, no reset
    always @(posedge clock) begin
        if (ce2) begin
            if (!we2) mem[a2] <= d2;
            q2 <= mem[a2];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every ack is matched against the oldest outstanding expectation
    always @(negedge clock) begin
        if (!reset && (ack0 || ack1)) begin
            if (ack0 && ack1) checkOutput("ack_exclusive", 1, 0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_ack", {ack0, ack1}, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                checkOutput("ack_who", ack1 ? 1 : 0, e.who);
                if (e.isRead) checkOutput("read_data", ack1 ? q1 : q0, e.q);
            end
        end
    end

    task automatic driveReq(input int who, input bit wr, input bit [13:0] addr, input bit [7:0] data);
        if (who == 0) begin rq0 = 1'b1; wr0 = wr; a0 = addr; d0 = data; end
        else          begin rq1 = 1'b1; wr1 = wr; a1 = addr; d1 = data; end
    endtask

    task automatic applyStimulus(input vec_t v);
        sb.push_back('{who: v.who, isRead: !v.wr, q: v.expQ});
        driveReq(v.who, v.wr, v.addr, v.data);
        @(negedge clock);
        checkOutput("issue_ce2", ce2, 1);
        checkOutput("issue_we2", we2, !v.wr);
        checkOutput("issue_a2", a2, v.addr);
        @(negedge clock);
        checkOutput("data_ce2", ce2, 0);
        checkOutput("data_ack", {ack0, ack1}, 0);
        @(negedge clock);
        checkOutput("ack_pulse", v.who == 0 ? ack0 : ack1, 1);
        rq0 = 1'b0;
        rq1 = 1'b0;
        @(negedge clock);
        checkOutput("ack_one_cycle", {ack0, ack1}, 0);
    endtask

    task automatic waitAnyAck(output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (!ok && cycles < 20) begin
            @(negedge clock);
            cycles++;
            if (ack0 || ack1) ok = 1'b1;
        end
        if (!ok) checkOutput("ack_timeout", 0, 1);
    endtask

    initial begin
        int cyc;
        bit ok;
        bit expSeq [10];

        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        bit ok;
        int expSeq [10];

        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'h00;
        mem[0] = 8'h3C;

        vecs[0] = '{who: 1, wr: 1, addr: 14'h1800, data: 8'hA5, expQ: 8'h00};
        vecs[1] = '{who: 1, wr: 0, addr: 14'h1800, data: 8'h00, expQ: 8'hA5};
        vecs[2] = '{who: 0, wr: 0, addr: 14'h0000, data: 8'h00, expQ: 8'h3C};
        vecs[3] = '{who: 0, wr: 1, addr: 14'h0100, data: 8'h5A, expQ: 8'h00};
        vecs[4] = '{who: 1, wr: 0, addr: 14'h0100, data: 8'h00, expQ: 8'h5A};
        vecs[5] = '{who: 0, wr: 1, addr: 14'h3FFF, data: 8'hC3, expQ: 8'h00};
        vecs[6] = '{who: 1, wr: 0, addr: 14'h3FFF, data: 8'h00, expQ: 8'hC3};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkOutput("idle_outputs", {ce2, we2, ack0, ack1, q0, q1}, {1'b0, 1'b1, 2'b00, 16'h0000});
        end

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Both held: four grants to 0, then one to 1, repeated
        expSeq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++)
            sb.push_back('{who: expSeq[i], isRead: 1'b1, q: (expSeq[i] == 0) ? 8'h3C : 8'hA5});
        driveReq(0, 1'b0, 14'h0000, 8'h00);
        driveReq(1, 1'b0, 14'h1800, 8'h00);
        for (int i = 0; i < 10; i++) begin
            waitAnyAck(cyc, ok);
            checkOutput("ack_spacing", cyc, 3);
        end
        rq0 = 1'b0;
        rq1 = 1'b0;
        repeat (3) @(negedge clock);

        // Simultaneous requests with run clear; rq1 dropped right after its grant
        sb.push_back('{who: 0, isRead: 1'b1, q: 8'h3C});
        sb.push_back('{who: 1, isRead: 1'b1, q: 8'hC3});
        driveReq(0, 1'b0, 14'h0000, 8'h00);
        driveReq(1, 1'b0, 14'h3FFF, 8'h00);
        waitAnyAck(cyc, ok);
        checkOutput("collide_first", ack0, 1);
        rq0 = 1'b0;
        @(negedge clock);
        checkOutput("collide_grant1_a2", {ce2, a2}, {1'b1, 14'h3FFF});
        rq1 = 1'b0;
        waitAnyAck(cyc, ok);
        checkOutput("collide_second", ack1, 1);
        repeat (3) @(negedge clock);

        // Reset lands on the ISSUE edge of a write
        driveReq(0, 1'b1, 14'h0100, 8'h77);
        @(negedge clock);
        checkOutput("rst_issue_ce2", {ce2, we2}, 2'b10);
        reset = 1'b1;
        rq0 = 1'b0;
        @(negedge clock);
        checkOutput("rst_outputs", {ce2, we2, ack0, ack1, q0, q1, d2}, {1'b0, 1'b1, 2'b00, 24'h000000});
        checkOutput("rst_a2", a2, 0);
        checkOutput("rst_ram_written", mem[14'h0100], 8'h77);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clock);
            checkOutput("rst_no_ack", {ack0, ack1}, 0);
        end
        applyStimulus('{who: 0, wr: 0, addr: 14'h0100, data: 8'h00, expQ: 8'h77});

        repeat (3) @(negedge clock);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dprf_arb.md
Name: dprf_arb

Overview:
- Two-requester arbiter and sequencer for the read/write port (port 2) of the dual-port frame RAM.
- Port 1 stays dedicated to the video fetcher. Port 2 is shared between the CPU (requester 0, priority) and the loader/DMA engine (requester 1), e.g. a snapshot or tape loader filling screen memory.
- Each requester uses a req/ack handshake.
- The block drives the RAM port 2 controls (ce2, active-low we2, a2, d2), captures q2, and includes an anti-starvation run counter for requester 1.

Parameters:
- KB, 16, RAM size in KB; AW = $clog2(KB*1024) address bits.
- MAXRUN, 4, maximum consecutive grants to requester 0 while requester 1 is waiting (1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rq0    in  1  requester 0 access request, level, held until ack0
- wr0    in  1  requester 0: 1 = write, 0 = read
- a0     in  AW  requester 0 address
- d0     in  8  requester 0 write data
- q0     out  8  requester 0 read data, valid when ack0 = 1
- ack0   out  1  one-cycle completion pulse for requester 0
- rq1, wr1, a1, d1, q1, ack1: same as above, for requester 1
- ce2    out  1  RAM port 2 clock enable
- we2    out  1  RAM port 2 write enable, active low
- a2     out  AW  RAM port 2 address
- d2     out  8  RAM port 2 write data
- q2     in  8  RAM port 2 read data (registered in RAM, one-cycle latency)

Behaviour:
- All outputs are registered.
- Reset values:
  - ce2 = 0, we2 = 1, a2 = 0, d2 = 0
  - ack0 = ack1 = 0, q0 = q1 = 0
  - state = IDLE, run = 0, grant register = 0
- FSM:
  - IDLE: if any rq is high, choose a winner, latch its a/d/wr into a2/d2/we2 (we2 = ~wr), set ce2 = 1, go to ISSUE. Otherwise remain in IDLE with ce2 = 0 and we2 = 1.
  - ISSUE: the RAM samples on this edge. Set ce2 = 0 and we2 = 1, go to DATA.
  - DATA: set the winner's ack to 1 for exactly one cycle. On a read, copy q2 into the winner's q. On a write, q is unchanged. Go to IDLE.
- Latency: rq seen high at edge T gives ack high during the cycle after edge T+2. Throughput is one access per 3 cycles.
- Arbitration in IDLE:
  - Only rq0 high: grant 0.
  - Only rq1 high: grant 1.
  - Both high: grant 0, unless run == MAXRUN, in which case grant 1.
- Run counter:
  - Increments on each grant to 0 while rq1 is high, saturating at MAXRUN.
  - Clears on a grant to 1, and in any IDLE cycle where rq1 is low.
- Requests are sampled only in IDLE. a/d/wr changes after a grant have no effect on the access in flight.
- Dropping rq after a grant does not cancel the access; ack still pulses.
- A requester holding rq high after its ack is re-arbitrated in the next IDLE cycle. It is not granted twice from a single sample.
- The loser's rq is untouched; it is served in a later arbitration cycle.
- Ack goes only to the granted requester; ack0 and ack1 are never high in the same cycle.
- Reset during ISSUE: a write already presented on the RAM port is performed by the RAM on that edge (the RAM has no reset), but no ack is issued. All registers take their reset values on that edge.
- Reset during DATA: no ack is issued and q is not updated.
- Address wrap: AW bits are passed through unchanged; no range checking.

Test Plan:
- Reset, then idle → ce2 = 0, we2 = 1, ack0 = ack1 = 0, q0 = q1 = 0 for 10 cycles.
- rq1 write a1 = 0x1800, d1 = 0xA5, then rq1 read of 0x1800 → first transaction: ce2 = 1 and we2 = 0 in one cycle, ack1 two cycles later; read: q1 = 0xA5 with ack1, ack0 never high.
- rq0 read of 0x0000 (preloaded 0x3C) → ce2 pulse one cycle after the rq0 sample, we2 = 1 throughout, ack0 with q0 = 0x3C after 2 cycles.
- rq0 and rq1 held high continuously, MAXRUN = 4 → grant sequence 0,0,0,0,1,0,0,0,0,1...; each ack 3 cycles apart.
- rq0 and rq1 asserted in the same cycle with run = 0 → requester 0 served first, requester 1 next; rq1 dropped after its grant still receives ack1.
- reset asserted in the ISSUE cycle of a write of 0x77 to 0x0100 → RAM[0x0100] = 0x77, no ack, all outputs at reset values the next cycle.
